// File: rtl/rca_pkg.sv
// Shared constants for the 64-bit ripple-carry adder issue controller.
package rca_pkg;

   localparam int RCA_DATA_W  = 64;
   localparam int RCA_ADD_LAT = 2;
   localparam int RCA_RES_W   = RCA_DATA_W + 1;
   localparam int ISSUE_CNT_W = 16;

   typedef struct packed {
      logic                  crout;
      logic [RCA_DATA_W-1:0] sum;
   } rca_result_t;

endpackage

// File: rtl/rca64_issue_ctrl_sync_fifo.sv
// Synchronous FIFO with occupancy count; push while full is accepted only with a same-cycle pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

   // Storage needs no reset: rdata is only consumed while the FIFO is non-empty.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rca64_issue_ctrl.sv
// Credit-based issue controller around a fixed-latency, non-stallable adder pipeline.
module rca64_issue_ctrl
   import rca_pkg::*;
#(
   parameter int DATA_W    = RCA_DATA_W,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4,
   parameter int ADD_LAT   = RCA_ADD_LAT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_op1,
   input  logic [DATA_W-1:0]      in_op2,
   output logic [DATA_W-1:0]      add_op1,
   output logic [DATA_W-1:0]      add_op2,
   input  logic [DATA_W-1:0]      add_sum,
   input  logic                   add_crout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_sum,
   output logic                   out_crout,
   output logic                   busy,
   output logic [ISSUE_CNT_W-1:0] issue_cnt
);

   localparam int OP_W   = 2 * DATA_W;
   localparam int RES_W  = DATA_W + 1;
   localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
   localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

   logic              in_push;
   logic              in_pop;
   logic [OP_W-1:0]   in_head;
   logic [IN_CW-1:0]  in_count;
   logic [IN_CW-1:0]  in_count_nxt;
   logic              in_full;
   logic              in_empty;

   logic              res_push;
   logic              out_pop;
   logic [RES_W-1:0]  out_head;
   logic [OUT_CW-1:0] out_count;
   logic              out_full;
   logic              out_empty;

   logic [ADD_LAT-1:0] pipe_v;
   logic [ADD_LAT-1:0] pipe_nxt;
   logic               issue;
   int                 inflight;

   sync_fifo #(.WIDTH(OP_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clock (clock),
      .reset (reset),
      .push  (in_push),
      .wdata ({in_op1, in_op2}),
      .pop   (in_pop),
      .rdata (in_head),
      .count (in_count),
      .full  (in_full),
      .empty (in_empty)
   );

   sync_fifo #(.WIDTH(RES_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clock (clock),
      .reset (reset),
      .push  (res_push),
      .wdata ({add_crout, add_sum}),
      .pop   (out_pop),
      .rdata (out_head),
      .count (out_count),
      .full  (out_full),
      .empty (out_empty)
   );

   assign in_push      = in_valid && in_ready && !in_full;
   assign in_pop       = issue;
   assign in_count_nxt = in_count + IN_CW'(in_push) - IN_CW'(in_pop);

   // Every result already in flight has a reserved slot, so the adder never meets a full FIFO.
   always_comb begin
      inflight = 0;
      for (int i = 0; i < ADD_LAT; i++) inflight += int'(pipe_v[i]);
   end

   assign issue   = !in_empty && ((int'(out_count) + inflight) < OUT_DEPTH);
   assign add_op1 = issue ? in_head[OP_W-1:DATA_W] : '0;
   assign add_op2 = issue ? in_head[DATA_W-1:0]    : '0;

   always_comb begin
      pipe_nxt    = pipe_v << 1;
      pipe_nxt[0] = issue;
   end

   assign res_push = pipe_v[ADD_LAT-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         pipe_v    <= '0;
         issue_cnt <= '0;
         in_ready  <= 1'b0;
      end else begin
         pipe_v    <= pipe_nxt;
         if (issue) issue_cnt <= issue_cnt + ISSUE_CNT_W'(1);
         in_ready  <= (in_count_nxt != IN_CW'(IN_DEPTH));
      end
   end

   assign out_valid = !out_empty;
   assign out_pop   = out_valid && out_ready;
   assign out_sum   = out_empty ? '0 : out_head[DATA_W-1:0];
   assign out_crout = out_empty ? 1'b0 : out_head[DATA_W];
   assign busy      = !in_empty || !out_empty || (|pipe_v);

   always_ff @(posedge clock) begin
      if (!reset) assert (!(res_push && out_full && !out_pop));
   end

endmodule
